// File: rtl/dht11_pkg.sv
// dht11_pkg: shared constants and parser state type for the DHT11 host command path.
package dht11_pkg;
    localparam logic [7:0] HEADER     = 8'hA5;
    localparam logic [7:0] CMD_SAMPLE = 8'h01;
    localparam logic [7:0] CMD_AUTO   = 8'h02;
    localparam logic [7:0] CMD_PERIOD = 8'h03;
    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_SUM    = 2'd1;
    localparam logic [1:0] ERR_CMD    = 2'd2;
    localparam logic [1:0] ERR_TMO    = 2'd3;
    typedef enum logic [2:0] {IDLE, GET_CMD, GET_ARG, GET_SUM, EXEC} state_t;
endpackage

// File: rtl/dht11_uart_cmd_rx_if.sv
// dht11_uart_cmd_rx_if: UART byte input, sensor handshake and command status bundle.
interface dht11_uart_cmd_rx_if;
    logic       RxD_data_ready;
    logic [7:0] RxD_data;
    logic       sensor_busy;
    logic       sample_en;
    logic       auto_en;
    logic [7:0] period_s;
    logic       cmd_ok;
    logic       cmd_err;
    logic [1:0] err_code;
    modport master (
        output RxD_data_ready, RxD_data, sensor_busy,
        input  sample_en, auto_en, period_s, cmd_ok, cmd_err, err_code
    );
    modport slave (
        input  RxD_data_ready, RxD_data, sensor_busy,
        output sample_en, auto_en, period_s, cmd_ok, cmd_err, err_code
    );
endinterface

// File: rtl/dht11_sample_timer.sv
// dht11_sample_timer: auto-sample second timer, pending request flag and sample_en issue.
module dht11_sample_timer #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter logic [7:0]  DEFAULT_PERIOD = 8'd1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       manual_req_i,
    input  logic       period_load_i,
    input  logic [7:0] period_i,
    input  logic       auto_load_i,
    input  logic       auto_val_i,
    input  logic       sensor_busy_i,
    output logic       sample_en_o,
    output logic       auto_en_o,
    output logic [7:0] period_s_o
);
    localparam int TW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    logic [TW-1:0] tick_q, tick_d;
    logic [7:0]    sec_q, sec_d, period_q, period_d;
    logic          auto_q, auto_d, pend_q, pend_d, sample_q, sample_d;
    logic          clr, sec_tick, expire, issue;
    always_comb begin
        auto_d   = auto_load_i ? auto_val_i : auto_q;
        period_d = period_load_i ? period_i : period_q;
        clr      = period_load_i | (auto_load_i & auto_val_i) | ~auto_q;
        sec_tick = tick_q == TW'(CLK_HZ - 1);
        expire   = ~clr & sec_tick & (sec_q + 8'd1 == period_q);
        tick_d   = (clr | sec_tick) ? '0 : tick_q + 1'b1;
        sec_d    = (clr | expire) ? '0 : sec_q + {7'd0, sec_tick};
        issue    = pend_q & ~sensor_busy_i;
        // a new request landing on the issue edge survives as the next pending request
        pend_d   = manual_req_i | expire | (pend_q & ~issue);
        sample_d = issue;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q   <= '0;
            sec_q    <= '0;
            period_q <= DEFAULT_PERIOD;
            auto_q   <= 1'b1;
            pend_q   <= 1'b0;
            sample_q <= 1'b0;
        end else begin
            tick_q   <= tick_d;
            sec_q    <= sec_d;
            period_q <= period_d;
            auto_q   <= auto_d;
            pend_q   <= pend_d;
            sample_q <= sample_d;
        end
    end
    assign sample_en_o = sample_q;
    assign auto_en_o   = auto_q;
    assign period_s_o  = period_q;
endmodule

// File: rtl/dht11_uart_cmd_rx.sv
// dht11_uart_cmd_rx: parses A5/cmd/arg/sum UART frames and drives the DHT11 sample timer.
module dht11_uart_cmd_rx import dht11_pkg::*; #(
    parameter int unsigned CLK_HZ         = 50000000,
    parameter int unsigned TIMEOUT_CYC    = 5000000,
    parameter logic [7:0]  HEADER         = dht11_pkg::HEADER,
    parameter logic [7:0]  DEFAULT_PERIOD = 8'd1
) (
    input logic               clk,
    input logic               rst_n,
    dht11_uart_cmd_rx_if.slave bus
);
    localparam int GW = $clog2(TIMEOUT_CYC + 1);
    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d, arg_q, arg_d, sum;
    logic [GW-1:0] gap_q, gap_d;
    logic          ok_q, ok_d, err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          rx, tmo, manual_req, period_load, auto_load;
    assign rx  = bus.RxD_data_ready;
    assign sum = cmd_q + arg_q;
    // a byte arriving on the expiry cycle wins over the timeout
    assign tmo = (state_q inside {GET_CMD, GET_ARG, GET_SUM}) && !rx && gap_q == GW'(TIMEOUT_CYC - 1);
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        arg_d       = arg_q;
        ok_d        = 1'b0;
        err_d       = 1'b0;
        code_d      = code_q;
        manual_req  = 1'b0;
        period_load = 1'b0;
        auto_load   = 1'b0;
        gap_d       = (state_q == IDLE || rx) ? '0 : gap_q + 1'b1;
        case (state_q)
            IDLE:    if (rx && bus.RxD_data == HEADER) state_d = GET_CMD;
            GET_CMD: if (rx) begin
                cmd_d   = bus.RxD_data;
                state_d = GET_ARG;
            end
            GET_ARG: if (rx) begin
                arg_d   = bus.RxD_data;
                state_d = GET_SUM;
            end
            GET_SUM: if (rx) begin
                err_d   = bus.RxD_data != sum;
                state_d = err_d ? IDLE : EXEC;
                code_d  = err_d ? ERR_SUM : code_q;
            end
            EXEC: begin
                state_d     = IDLE;
                manual_req  = cmd_q == CMD_SAMPLE;
                auto_load   = cmd_q == CMD_AUTO;
                period_load = cmd_q == CMD_PERIOD && arg_q != 8'd0;
                ok_d        = manual_req | auto_load | period_load;
                err_d       = ~ok_d;
                code_d      = ok_d ? code_q : ERR_CMD;
            end
            default: state_d = IDLE;
        endcase
        if (tmo) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TMO;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            arg_q   <= '0;
            gap_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            arg_q   <= arg_d;
            gap_q   <= gap_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end
    assign bus.cmd_ok   = ok_q;
    assign bus.cmd_err  = err_q;
    assign bus.err_code = code_q;
    dht11_sample_timer #(.CLK_HZ(CLK_HZ), .DEFAULT_PERIOD(DEFAULT_PERIOD)) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .manual_req_i (manual_req),
        .period_load_i(period_load),
        .period_i     (arg_q),
        .auto_load_i  (auto_load),
        .auto_val_i   (arg_q[0]),
        .sensor_busy_i(bus.sensor_busy),
        .sample_en_o  (bus.sample_en),
        .auto_en_o    (bus.auto_en),
        .period_s_o   (bus.period_s)
    );
endmodule

// File: tb/tb_dht11_uart_cmd_rx.sv
// tb_dht11_uart_cmd_rx: scoreboard bench; stimulus queues expected pulses, a monitor pops them.
module tb_dht11_uart_cmd_rx;
    import dht11_pkg::*;
    localparam int K_OK = 0, K_ERR = 1, K_SMP = 2;
    typedef struct {int kind; int code; int lo; int hi;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0, total = 0, bad = 0, last_s = 0, s_en = 0, b_rel = 0, ak = 0, nact = 0;
    exp_t q[$];
    exp_t e;
    dht11_uart_cmd_rx_if bus();
    dht11_uart_cmd_rx #(.CLK_HZ(100), .TIMEOUT_CYC(50)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        nact = int'(bus.cmd_ok) + int'(bus.cmd_err) + int'(bus.sample_en);
        if (rst_n && nact != 0) begin
            ak = bus.cmd_ok ? K_OK : bus.cmd_err ? K_ERR : K_SMP;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got kind=%0d code=%0d at cyc=%0d, required no event", ak, bus.err_code, cyc);
            end else begin
                e = q.pop_front();
                if (nact != 1 || ak != e.kind || int'(bus.err_code) != e.code || cyc < e.lo || cyc > e.hi) begin
                    bad++;
                    $display("FAIL event: got kind=%0d n=%0d code=%0d cyc=%0d, required kind=%0d code=%0d cyc=%0d..%0d",
                             ak, nact, bus.err_code, cyc, e.kind, e.code, e.lo, e.hi);
                end
            end
        end
    end
    task automatic push(input int k, input int c, input int lo, input int hi);
        exp_t x;
        x.kind = k; x.code = c; x.lo = lo; x.hi = hi;
        q.push_back(x);
    endtask
    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.RxD_data_ready = 1'b1;
        bus.RxD_data = b;
        last_s = cyc + 1;
        @(negedge clk);
        bus.RxD_data_ready = 1'b0;
    endtask
    // lat: 0 for checksum rejects, 1 for EXEC outcomes
    task automatic frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] s,
                         input int k, input int code, input int lat);
        send(HEADER);
        send(c);
        send(a);
        @(negedge clk);
        bus.RxD_data_ready = 1'b1;
        bus.RxD_data = s;
        last_s = cyc + 1;
        push(k, code, last_s + lat, last_s + lat);
        @(negedge clk);
        bus.RxD_data_ready = 1'b0;
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_sample_en"}, int'(bus.sample_en), 0);
        chk({tag, "_cmd_ok"}, int'(bus.cmd_ok), 0);
        chk({tag, "_cmd_err"}, int'(bus.cmd_err), 0);
        chk({tag, "_err_code"}, int'(bus.err_code), 0);
        chk({tag, "_auto_en"}, int'(bus.auto_en), 1);
        chk({tag, "_period_s"}, int'(bus.period_s), 1);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.RxD_data_ready = 1'b0;
        bus.RxD_data = 8'h00;
        bus.sensor_busy = 1'b0;
        idle(3);
        chk_reset("rst");
        rst_n = 1'b1;
        // manual sample: ok at S+1, sample_en at S+2
        frame(8'h01, 8'h00, 8'h01, K_OK, 0, 1);
        push(K_SMP, 0, last_s + 2, last_s + 2);
        idle(4);
        chk("t1_err_code", int'(bus.err_code), 0);
        // period 5 then rejected period 0; auto samples 500 cycles apart
        frame(8'h03, 8'h05, 8'h08, K_OK, 0, 1);
        s_en = last_s;
        frame(8'h03, 8'h00, 8'h03, K_ERR, 2, 1);
        push(K_SMP, 2, s_en + 501, s_en + 503);
        push(K_SMP, 2, s_en + 1001, s_en + 1003);
        idle(3);
        chk("t2_period_s", int'(bus.period_s), 5);
        chk("t2_err_code", int'(bus.err_code), 2);
        wait_until(s_en + 1010);
        // bad checksum, then disable auto
        frame(8'h02, 8'h00, 8'h03, K_ERR, 1, 0);
        idle(2);
        chk("t3_auto_kept", int'(bus.auto_en), 1);
        chk("t3_err_code", int'(bus.err_code), 1);
        frame(8'h02, 8'h00, 8'h02, K_OK, 1, 1);
        idle(3);
        chk("t3_auto_off", int'(bus.auto_en), 0);
        idle(700);
        // inter-byte timeout after A5 01
        send(HEADER);
        send(8'h01);
        push(K_ERR, 3, last_s + 49, last_s + 51);
        idle(60);
        chk("t4_err_code", int'(bus.err_code), 3);
        frame(8'h01, 8'h00, 8'h01, K_OK, 3, 1);
        push(K_SMP, 3, last_s + 2, last_s + 2);
        idle(5);
        // re-enable auto, then land a manual EXEC on the auto expiry edge while busy
        frame(8'h02, 8'h01, 8'h03, K_OK, 3, 1);
        s_en = last_s;
        bus.sensor_busy = 1'b1;
        idle(2);
        chk("t5_auto_on", int'(bus.auto_en), 1);
        wait_until(s_en + 492);
        frame(8'h01, 8'h00, 8'h01, K_OK, 3, 1);
        chk("t5_coincide", last_s, s_en + 500);
        idle(20);
        b_rel = cyc;
        push(K_SMP, 3, b_rel + 1, b_rel + 1);
        bus.sensor_busy = 1'b0;
        idle(10);
        // reset mid-frame; trailing bytes must be discarded
        send(HEADER);
        send(8'h01);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        idle(2);
        rst_n = 1'b1;
        send(8'h00);
        send(8'h01);
        idle(20);
        chk("queue_empty", q.size(), 0);
        chk("final_err_code", int'(bus.err_code), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
